conv_window_seq: RTL

Sequential, parametrised successor to the combinational window convolver. It convolves one MAX_K×MAX_K window of signed fixed-point samples with a same-size filter at a runtime-selectable kernel size. It processes one kernel row per cycle, rounds and saturates the result, and can optionally chain partial sums across input channels. It sits between the window line-buffer and the feature-map writer, with valid/ready handshakes on both sides.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_row_mac.sv | 29 ++
 rtl/conv_window_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential window convolver.
//   DATA_W/FRAC_W : sample format (Q5.10 by default)
//   MAX_K         : largest kernel side held in the window/filter arrays
//   ACC_W         : accumulator width, Q(ACC_W-2*FRAC_W).(2*FRAC_W)
//   round_sat()   : accumulator -> rounded, saturated output sample
package conv_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  localparam int MAX_K  = 5;
  localparam int ACC_W  = 40;

  typedef logic signed [DATA_W-1:0] fixed_t;

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_e;

  typedef struct packed {
    logic   sat;
    fixed_t val;
  } rs_t;

  // Round half up, drop the extra FRAC_W fraction bits, clip to DATA_W.
  // One guard bit keeps the rounding add from overflowing at ACC_W max.
  function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W:0] t;
    rs_t r;
    t = {acc[ACC_W-1], acc} + {{(ACC_W+1-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    t = t >>> FRAC_W;
    // Value fits when every bit above the output sign bit matches it.
    if (t[ACC_W:DATA_W-1] == {(ACC_W-DATA_W+2){t[ACC_W]}}) begin
      r.sat = 1'b0;
      r.val = t[DATA_W-1:0];
    end else begin
      r.sat = 1'b1;
      r.val = t[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return r;
  endfunction
endpackage

// File: rtl/conv_row_mac.sv
// Combinational dot product of one kernel row.
//   win_row/flt_row : MAX_K signed samples / coefficients of the current row
//   k               : active kernel side; lanes c >= k contribute nothing
//   dot             : full-precision signed sum of the active lane products
module conv_row_mac #(
  parameter int DATA_W = 16,
  parameter int MAX_K  = 5,
  parameter int KW     = 3,
  parameter int DOT_W  = 2*DATA_W + $clog2(MAX_K)
) (
  input  logic [MAX_K-1:0][DATA_W-1:0] win_row,
  input  logic [MAX_K-1:0][DATA_W-1:0] flt_row,
  input  logic [KW-1:0]                k,
  output logic signed [DOT_W-1:0]      dot
);
  logic signed [2*DATA_W-1:0] prod [MAX_K];

  for (genvar c = 0; c < MAX_K; c++) begin : g_lane
    assign prod[c] = $signed(win_row[c]) * $signed(flt_row[c]);
  end

  always_comb begin
    dot = '0;
    for (int c = 0; c < MAX_K; c++) begin
      if (KW'(c) < k)
        dot = dot + {{(DOT_W-2*DATA_W){prod[c][2*DATA_W-1]}}, prod[c]};
    end
  end
endmodule

// File: rtl/conv_window_seq.sv
// Sequential MAX_K x MAX_K window convolver, one kernel row per cycle.
//   clk/rst            : clock, synchronous active-high reset
//   in_valid/in_ready  : accept handshake for window/filter/ksize/bias/acc_en
//   window/filter      : MAX_K*MAX_K signed entries, index r*MAX_K+c
//   ksize              : kernel side; 0 or > MAX_K selects MAX_K
//   bias               : added once per fresh result (ignored when acc_en=1)
//   acc_en             : continue from the previous unrounded accumulator
//   out_valid/out_ready: result handshake; result/sat held until accepted
module conv_window_seq #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int FRAC_W = conv_pkg::FRAC_W,
  parameter int MAX_K  = conv_pkg::MAX_K,
  parameter int ACC_W  = conv_pkg::ACC_W,
  localparam int KW    = $clog2(MAX_K+1),
  localparam int NT    = MAX_K*MAX_K
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NT-1:0][DATA_W-1:0] window,
  input  logic [NT-1:0][DATA_W-1:0] filter,
  input  logic [KW-1:0]             ksize,
  input  logic [DATA_W-1:0]         bias,
  input  logic                      acc_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         result,
  output logic                      sat
);
  import conv_pkg::*;

  localparam int RW    = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int DOT_W = 2*DATA_W + $clog2(MAX_K);

  state_e state_q, state_d;
  // Stored as [row][col] so the current row can be picked by row_q directly.
  logic [MAX_K-1:0][MAX_K-1:0][DATA_W-1:0] win_q, win_d, flt_q, flt_d;
  logic [KW-1:0]            k_q, k_d;
  logic [RW-1:0]            row_q, row_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, prev_q, prev_d;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     sat_q, sat_d, ov_q, ov_d;

  logic [KW-1:0]            k_eff;
  logic signed [DOT_W-1:0]  dot;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_next, bias_acc;
  logic                     last_row;
  rs_t                      rs;

  conv_row_mac #(.DATA_W(DATA_W), .MAX_K(MAX_K), .KW(KW), .DOT_W(DOT_W)) u_row_mac (
    .win_row (win_q[row_q]),
    .flt_row (flt_q[row_q]),
    .k       (k_q),
    .dot     (dot)
  );

  always_comb begin
    k_eff    = (ksize == '0 || ksize > KW'(MAX_K)) ? KW'(MAX_K) : ksize;
    bias_acc = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
    // Saturating accumulate: a sign mismatch in the guard bit means overflow.
    acc_sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-DOT_W){dot[DOT_W-1]}}, dot};
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
      acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = acc_sum[ACC_W-1:0];
    rs       = round_sat(acc_next);
    last_row = (KW'(row_q) + KW'(1)) == k_q;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    flt_d    = flt_q;
    k_d      = k_q;
    row_d    = row_q;
    acc_d    = acc_q;
    prev_d   = prev_q;
    result_d = result_q;
    sat_d    = sat_q;
    ov_d     = ov_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        win_d   = window;
        flt_d   = filter;
        k_d     = k_eff;
        row_d   = '0;
        acc_d   = acc_en ? prev_q : bias_acc;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_next;
        row_d = row_q + RW'(1);
        if (last_row) begin
          prev_d   = acc_next;
          result_d = rs.val;
          sat_d    = rs.sat;
          ov_d     = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      flt_q    <= '0;
      k_q      <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      prev_q   <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      flt_q    <= flt_d;
      k_q      <= k_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      prev_q   <= prev_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      ov_q     <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign result    = result_q;
  assign sat       = sat_q;
endmodule
